// File: rtl/f_mult_arbiter_if.sv
// Bundle of requester, response and shared-multiplier signals for f_mult_arbiter.
// The slave modport is the arbiter's view; master is the surrounding system's view.
interface f_mult_arbiter_if #(
    parameter int FLEN  = 64,
    parameter int N_REQ = 4
);
    logic [N_REQ-1:0]      req_vld;
    logic [N_REQ*FLEN-1:0] req_a;
    logic [N_REQ*FLEN-1:0] req_b;
    logic [N_REQ-1:0]      req_rdy;
    logic [N_REQ-1:0]      rsp_vld;
    logic [FLEN-1:0]       rsp_res;
    logic                  rsp_err;
    logic                  rsp_timeout;
    logic                  busy;
    logic                  fpu_up_valid;
    logic [FLEN-1:0]       fpu_a;
    logic [FLEN-1:0]       fpu_b;
    logic [FLEN-1:0]       fpu_res;
    logic                  fpu_down_valid;
    logic                  fpu_busy;
    logic                  fpu_error;

    modport slave (
        input  req_vld, req_a, req_b,
        input  fpu_res, fpu_down_valid, fpu_busy, fpu_error,
        output req_rdy, rsp_vld, rsp_res, rsp_err, rsp_timeout, busy,
        output fpu_up_valid, fpu_a, fpu_b
    );

    modport master (
        output req_vld, req_a, req_b,
        output fpu_res, fpu_down_valid, fpu_busy, fpu_error,
        input  req_rdy, rsp_vld, rsp_res, rsp_err, rsp_timeout, busy,
        input  fpu_up_valid, fpu_a, fpu_b
    );
endinterface

// File: rtl/f_mult_arbiter.sv
// Round-robin sharing of one f_mult between N_REQ requesters.
// One operation in flight; result/error/timeout are routed back to its owner.
module f_mult_arbiter #(
    parameter int FLEN    = 64,
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic            clk,
    input  logic            rst,
    f_mult_arbiter_if.slave arb
);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CNT_W = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DRAIN} state_t;

    state_t             r_state;
    logic [IDX_W-1:0]   r_rr_ptr;
    logic [IDX_W-1:0]   r_owner;
    logic [CNT_W-1:0]   r_cnt;

    state_t             w_state_next;
    logic [IDX_W-1:0]   w_rr_next;
    logic [IDX_W-1:0]   w_owner_next;
    logic [CNT_W-1:0]   w_cnt_next;
    logic               w_found;
    logic [IDX_W-1:0]   w_grant_idx;
    logic               w_issue_opp;
    logic               w_issue;
    logic               w_rsp_fire;
    logic [FLEN-1:0]    w_rsp_res;
    logic               w_rsp_err;
    logic               w_rsp_to;
    logic               w_run;

    // Modulo-N_REQ add that also works when N_REQ is not a power of two.
    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= N_REQ) s = s - N_REQ;
        return IDX_W'(s);
    endfunction

    // Find the first pending request starting at the round-robin pointer.
    always_comb begin
        w_found     = 1'b0;
        w_grant_idx = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!w_found && arb.req_vld[wrap_add(r_rr_ptr, k)]) begin
                w_found     = 1'b1;
                w_grant_idx = wrap_add(r_rr_ptr, k);
            end
        end
    end

    // Next-state logic: issue, response routing, timeout and drain handling.
    always_comb begin
        w_state_next = r_state;
        w_rr_next    = r_rr_ptr;
        w_owner_next = r_owner;
        w_cnt_next   = r_cnt;
        w_issue_opp  = 1'b0;
        w_rsp_fire   = 1'b0;
        w_rsp_res    = '0;
        w_rsp_err    = 1'b0;
        w_rsp_to     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_issue_opp = !arb.fpu_busy;
            end
            S_WAIT: begin
                w_cnt_next = r_cnt + 1'b1;
                if (arb.fpu_down_valid) begin
                    // A returning result wins over a simultaneous timeout.
                    w_rsp_fire   = 1'b1;
                    w_rsp_res    = arb.fpu_res;
                    w_rsp_err    = arb.fpu_error;
                    w_issue_opp  = 1'b1;
                    w_state_next = S_IDLE;
                end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                    w_rsp_fire   = 1'b1;
                    w_rsp_err    = 1'b1;
                    w_rsp_to     = 1'b1;
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                // Wait for the abandoned operation to flush; its result is dropped.
                if (!arb.fpu_busy && !arb.fpu_down_valid) w_state_next = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
        w_issue = w_issue_opp && w_found;
        if (w_issue) begin
            w_owner_next = w_grant_idx;
            w_rr_next    = wrap_add(w_grant_idx, 1);
            w_cnt_next   = '0;
            w_state_next = S_WAIT;
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_rr_ptr <= '0;
            r_owner  <= '0;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_state_next;
            r_rr_ptr <= w_rr_next;
            r_owner  <= w_owner_next;
            r_cnt    <= w_cnt_next;
        end
    end

    // All control outputs are held low while reset is asserted.
    assign w_run = rst;

    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_onehot
            assign arb.req_rdy[gi] = w_run && w_issue    && (w_grant_idx == IDX_W'(gi));
            assign arb.rsp_vld[gi] = w_run && w_rsp_fire && (r_owner == IDX_W'(gi));
        end
    endgenerate

    assign arb.fpu_up_valid = w_run && w_issue;
    assign arb.fpu_a        = (w_run && w_issue) ? arb.req_a[w_grant_idx*FLEN +: FLEN] : '0;
    assign arb.fpu_b        = (w_run && w_issue) ? arb.req_b[w_grant_idx*FLEN +: FLEN] : '0;
    assign arb.rsp_res      = (w_run && w_rsp_fire) ? w_rsp_res : '0;
    assign arb.rsp_err      = w_run && w_rsp_err;
    assign arb.rsp_timeout  = w_run && w_rsp_to;
    assign arb.busy         = w_run && (r_state != S_IDLE);

endmodule

// File: doc/f_mult_arbiter.md
Name: f_mult_arbiter

Overview:
- Shares one f_mult instance between N_REQ independent requesters using round-robin arbitration.
- Keeps exactly one operation in flight and records which requester owns it.
- Routes the result, error flag and a timeout indication back to that owner.
- Sits between FSM-based FP compute blocks (discriminant, polynomial evaluators) and a single shared multiplier, so those blocks no longer need a private f_mult each.

Parameters:
- FLEN, 64, operand/result width in bits (FP64).
- N_REQ, 4, number of requesters (2..8).
- TIMEOUT, 64, maximum cycles to wait for fpu_down_valid after issue; must be ≥ 2.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-low reset (rst == 0 resets on the clk edge).
- req_vld  in  N_REQ  per-requester operation request.
- req_a  in  N_REQ*FLEN  operand a; requester i occupies bits [i*FLEN +: FLEN].
- req_b  in  N_REQ*FLEN  operand b; same packing as req_a.
- req_rdy  out  N_REQ  one-hot grant; req_vld[i] & req_rdy[i] means accepted.
- rsp_vld  out  N_REQ  one-hot result pulse to the owner.
- rsp_res  out  FLEN  result, shared by all requesters; meaningful only with rsp_vld.
- rsp_err  out  1  fpu_error, or timeout; meaningful only with rsp_vld.
- rsp_timeout  out  1  response was generated by timeout.
- busy  out  1  state != IDLE.
- fpu_up_valid  out  1  f_mult up_valid.
- fpu_a  out  FLEN  f_mult a.
- fpu_b  out  FLEN  f_mult b.
- fpu_res  in  FLEN  f_mult res.
- fpu_down_valid  in  1  f_mult down_valid.
- fpu_busy  in  1  f_mult busy.
- fpu_error  in  1  f_mult error.

Behaviour:
- States and reset values
  - States: IDLE, WAIT, DRAIN.
  - While rst == 0: state <= IDLE, rr_ptr <= 0, owner <= 0, cnt <= 0.
  - Also while rst == 0: req_rdy, rsp_vld, rsp_err, rsp_timeout, fpu_up_valid and busy are all forced to 0.
  - fpu_a and fpu_b are 0 when fpu_up_valid == 0.
- Issue opportunity
  - Occurs when (state == IDLE && !fpu_busy), or when (state == WAIT && fpu_down_valid).
  - The second case gives back-to-back issue in the same cycle the previous result returns.
- Arbitration
  - On an issue opportunity with any req_vld set, grant g = the first set bit of req_vld searching rr_ptr, rr_ptr+1, …, wrapping modulo N_REQ.
  - Same cycle, combinationally: req_rdy[g] = 1, fpu_up_valid = 1, fpu_a = req_a[g], fpu_b = req_b[g].
  - Registered on that edge: owner <= g, rr_ptr <= (g+1) mod N_REQ, cnt <= 0, state <= WAIT.
  - Requests not granted remain pending; requesters must hold req_vld and operands stable until granted.
- WAIT
  - cnt increments every cycle.
  - If fpu_down_valid: rsp_vld[owner] = 1, rsp_res = fpu_res, rsp_err = fpu_error, rsp_timeout = 0, all combinational in the same cycle (zero added latency).
  - Next state on fpu_down_valid: WAIT again if a new grant was issued that cycle, otherwise IDLE.
- Timeout
  - If fpu_down_valid is not asserted while cnt == TIMEOUT-1: rsp_vld[owner] = 1, rsp_res = 0, rsp_err = 1, rsp_timeout = 1.
  - state <= DRAIN; no issue happens that cycle.
  - fpu_down_valid in the same cycle as cnt == TIMEOUT-1 takes priority: normal response, no timeout.
- DRAIN
  - Any fpu_down_valid is discarded; no rsp_vld is produced.
  - Exits to IDLE on the first cycle with fpu_busy == 0 and fpu_down_valid == 0.
- General rules
  - At most one rsp_vld bit per cycle; at most one req_rdy bit per cycle.
  - Fairness: a continuously asserted request is granted within N_REQ issues.
- fpu_down_valid in IDLE: ignored; does not update any state or output.
- Reset mid-operation: the in-flight result is lost and no response is produced. The shared f_mult must be reset by the same rst.

Test Plan:
- Single request: req_vld=4'b0010, req_a[1]=64'h4000_0000_0000_0000 (2.0), req_b[1]=64'h4008_0000_0000_0000 (3.0) -> req_rdy=4'b0010 in the same cycle; later rsp_vld=4'b0010 with rsp_res=64'h4018_0000_0000_0000 (6.0), rsp_err=0; busy high from the issue edge until the response cycle.
- All four requesting continuously from reset -> grant order 0,1,2,3,0; each rsp_vld one-hot matches the grant order; new fpu_up_valid coincides with each fpu_down_valid (back-to-back issue).
- Error routing: requester 2 sends 64'h7FF0_0000_0000_0000 (+Inf) × 1.0 -> rsp_vld=4'b0100, rsp_err=1, rsp_timeout=0.
- Timeout: model f_mult stalls with busy=1 and no down_valid; TIMEOUT=8 -> rsp_vld[owner], rsp_err=1, rsp_timeout=1 on the 8th WAIT cycle; a late down_valid is dropped in DRAIN; IDLE is re-entered once fpu_busy=0.
- Reset mid-operation: drive rst=0 for one cycle while in WAIT -> all outputs 0, busy=0, next grant goes to requester 0 (rr_ptr reset).
- Race: fpu_down_valid arrives exactly at cnt=TIMEOUT-1 -> normal response with rsp_timeout=0, and no transition to DRAIN.
